ecc_decode_ctrl: RTL and testbench

Sequencing controller for the parity-check syndrome datapath (`Hy'=s` over H1 for 8-bit and H2 for 16-bit codewords). It accepts noisy codewords over a valid/ready handshake and registers them. It then drives the syndrome sub-module, classifies the result, corrects single-bit errors and returns the corrected word with status and per-class error counters. It sits between the codeword source and the data consumer in the decoder top level.

---
 rtl/ecc_pkg.sv | 37 +++
 rtl/ecc_syndrome.sv | 30 +++
 rtl/ecc_decode_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ecc_decode_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared types and constants for the ECC decode controller.
//   ecc_state_t  - controller FSM states
//   ecc_status_t - result classification reported on out_status
//   H1_COLS      - parity-check columns for 8-bit codewords, index = bit position
//   H2_COLS      - parity-check columns for 16-bit codewords, index = bit position
//   MODE_8BIT    - in_mode encoding that selects 8-bit/H1; any other value selects 16-bit/H2
package ecc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYND = 2'd1,
    S_CORR = 2'd2,
    S_OUT  = 2'd3
  } ecc_state_t;

  typedef enum logic [1:0] {
    ST_NO_ERR = 2'd0,
    ST_SINGLE = 2'd1,
    ST_DOUBLE = 2'd2
  } ecc_status_t;

  localparam logic [1:0] MODE_8BIT = 2'd0;

  // Packed so that H1_COLS[j] is the column for codeword bit j.
  localparam logic [7:0][3:0] H1_COLS = {
    4'b1111, 4'b1110, 4'b1101, 4'b1011,
    4'b1000, 4'b1100, 4'b1010, 4'b1001
  };

  localparam logic [15:0][4:0] H2_COLS = {
    5'b11111, 5'b11110, 5'b11101, 5'b11100,
    5'b11011, 5'b11010, 5'b11001, 5'b10111,
    5'b10110, 5'b10101, 5'b10011, 5'b10000,
    5'b11000, 5'b10100, 5'b10010, 5'b10001
  };

endpackage

// File: rtl/ecc_syndrome.sv
// ecc_syndrome: combinational syndrome s = H*y over GF(2).
//   word_i     - codeword (bits [7:0] used in 8-bit mode, [15:0] in 16-bit mode)
//   mode_i     - MODE_8BIT selects H1, anything else selects H2
//   syndrome_o - 5-bit syndrome; bit 4 is always 0 in 8-bit mode
module ecc_syndrome
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [1:0]            mode_i,
  output logic [4:0]            syndrome_o
);

  // NOTE: blocking '=' is correct in combinational blocks; the XOR
  // accumulation relies on each iteration seeing the previous result.
  always_comb begin
    syndrome_o = '0;
    if (mode_i == MODE_8BIT) begin
      for (int j = 0; j < 8; j++) begin
        if (word_i[j]) syndrome_o[3:0] = syndrome_o[3:0] ^ H1_COLS[j];
      end
    end else begin
      for (int j = 0; j < 16; j++) begin
        if (word_i[j]) syndrome_o = syndrome_o ^ H2_COLS[j];
      end
    end
  end

endmodule

// File: rtl/ecc_decode_ctrl.sv
// ecc_decode_ctrl: sequences one codeword at a time through syndrome
// computation, classification and single-bit correction.
//   clk, rst                        - clock, asynchronous active-high reset
//   in_valid/in_ready/in_word/in_mode - codeword input handshake
//   out_valid/out_ready               - result handshake
//   out_word/out_status/out_syndrome  - corrected word, class, raw syndrome
//   clr_cnt                           - synchronous clear of both counters
//   single_cnt/double_cnt             - saturating per-class result counters
module ecc_decode_ctrl
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_word,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_word,
  output logic [1:0]            out_status,
  output logic [4:0]            out_syndrome,
  input  logic                  clr_cnt,
  output logic [CNT_WIDTH-1:0]  single_cnt,
  output logic [CNT_WIDTH-1:0]  double_cnt
);

  localparam logic [DATA_WIDTH-1:0] MASK8  = DATA_WIDTH'(16'h00FF);
  localparam logic [DATA_WIDTH-1:0] MASK16 = DATA_WIDTH'(16'hFFFF);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

  ecc_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0]  word_q, word_d;
  logic [1:0]             mode_q, mode_d;
  logic [4:0]             synd_q, synd_d;
  logic [DATA_WIDTH-1:0]  out_word_q, out_word_d;
  ecc_status_t            status_q, status_d;
  logic [CNT_WIDTH-1:0]   single_cnt_q, single_cnt_d;
  logic [CNT_WIDTH-1:0]   double_cnt_q, double_cnt_d;

  logic [4:0]             synd_comb;

  ecc_syndrome #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_syndrome (
    .word_i     (word_q),
    .mode_i     (mode_q),
    .syndrome_o (synd_comb)
  );

  // Classification of the registered syndrome.
  logic                  wide;
  logic                  p_bit;
  logic                  s_nz;
  logic                  hit;
  logic [3:0]            hit_idx;
  logic [DATA_WIDTH-1:0] flip_mask;
  ecc_status_t           cls;

  always_comb begin
    wide      = (mode_q != MODE_8BIT);
    p_bit     = wide ? synd_q[4] : synd_q[3];
    s_nz      = wide ? (|synd_q[3:0]) : (|synd_q[2:0]);
    hit       = 1'b0;
    hit_idx   = '0;
    flip_mask = '0;
    // Column lookup: find the bit whose H column equals the syndrome.
    if (wide) begin
      for (int j = 0; j < 16; j++) begin
        if (synd_q == H2_COLS[j]) begin
          hit     = 1'b1;
          hit_idx = 4'(j);
        end
      end
    end else begin
      for (int j = 0; j < 8; j++) begin
        if (synd_q == {1'b0, H1_COLS[j]}) begin
          hit     = 1'b1;
          hit_idx = 4'(j);
        end
      end
    end
    if (hit) flip_mask[hit_idx] = 1'b1;
    // A parity-odd syndrome with no matching column is treated as
    // uncorrectable rather than guessing a bit to flip.
    if (!p_bit && !s_nz)  cls = ST_NO_ERR;
    else if (p_bit && hit) cls = ST_SINGLE;
    else                   cls = ST_DOUBLE;
  end

  // NOTE: every signal assigned here gets a default first so no latch is
  // inferred on paths that do not update it.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    mode_d       = mode_q;
    synd_d       = synd_q;
    out_word_d   = out_word_q;
    status_d     = status_q;
    single_cnt_d = single_cnt_q;
    double_cnt_d = double_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          word_d  = in_word & ((in_mode == MODE_8BIT) ? MASK8 : MASK16);
          mode_d  = in_mode;
          state_d = S_SYND;
        end
      end
      S_SYND: begin
        synd_d  = synd_comb;
        state_d = S_CORR;
      end
      S_CORR: begin
        status_d   = cls;
        out_word_d = (cls == ST_SINGLE) ? (word_q ^ flip_mask) : word_q;
        if (cls == ST_SINGLE && single_cnt_q != '1) single_cnt_d = single_cnt_q + CNT_ONE;
        if (cls == ST_DOUBLE && double_cnt_q != '1) double_cnt_d = double_cnt_q + CNT_ONE;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Clear wins over any increment computed above.
    if (clr_cnt) begin
      single_cnt_d = '0;
      double_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      mode_q       <= MODE_8BIT;
      synd_q       <= '0;
      out_word_q   <= '0;
      status_q     <= ST_NO_ERR;
      single_cnt_q <= '0;
      double_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      mode_q       <= mode_d;
      synd_q       <= synd_d;
      out_word_q   <= out_word_d;
      status_q     <= status_d;
      single_cnt_q <= single_cnt_d;
      double_cnt_q <= double_cnt_d;
    end
  end

  // Gated by rst so the source sees not-ready while reset is held.
  assign in_ready     = (state_q == S_IDLE) && !rst;
  assign out_valid    = (state_q == S_OUT);
  assign out_word     = out_word_q;
  assign out_status   = status_q;
  assign out_syndrome = synd_q;
  assign single_cnt   = single_cnt_q;
  assign double_cnt   = double_cnt_q;

endmodule

// File: tb/tb_ecc_decode_ctrl.sv
// Directed testbench for ecc_decode_ctrl. A second instance with 3-bit
// counters shares all inputs so counter saturation is reachable quickly.
module tb_ecc_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_word;
  logic [1:0]  in_mode;
  logic        out_ready;
  logic        clr_cnt;

  logic        in_ready, out_valid;
  logic [31:0] out_word;
  logic [1:0]  out_status;
  logic [4:0]  out_syndrome;
  logic [15:0] single_cnt, double_cnt;

  logic        sat_in_ready, sat_out_valid;
  logic [31:0] sat_out_word;
  logic [1:0]  sat_out_status;
  logic [4:0]  sat_out_syndrome;
  logic [2:0]  sat_single_cnt, sat_double_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ecc_decode_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_word      (in_word),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_word     (out_word),
    .out_status   (out_status),
    .out_syndrome (out_syndrome),
    .clr_cnt      (clr_cnt),
    .single_cnt   (single_cnt),
    .double_cnt   (double_cnt)
  );

  ecc_decode_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(3)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (sat_in_ready),
    .in_word      (in_word),
    .in_mode      (in_mode),
    .out_valid    (sat_out_valid),
    .out_ready    (out_ready),
    .out_word     (sat_out_word),
    .out_status   (sat_out_status),
    .out_syndrome (sat_out_syndrome),
    .clr_cnt      (clr_cnt),
    .single_cnt   (sat_single_cnt),
    .double_cnt   (sat_double_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one codeword, check latency and the result fields, and
  // optionally complete the output handshake.
  task automatic run_word(input string tag, input logic [31:0] w, input logic [1:0] m,
                          input logic [31:0] exp_word, input logic [1:0] exp_st,
                          input logic [4:0] exp_syn, input bit release_out);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_word  = w;
    in_mode  = m;
    tick();                          // capture edge (1st)
    in_valid = 1'b0;
    in_word  = 32'hFFFF_FFFF;        // later input changes must not matter
    in_mode  = m ^ 2'b11;
    check({tag, " busy"}, 32'(in_ready), 32'd0);
    check({tag, " valid@1"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, " valid@2"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, " valid@3"}, 32'(out_valid), 32'd1);
    check({tag, " word"}, out_word, exp_word);
    check({tag, " status"}, 32'(out_status), 32'(exp_st));
    check({tag, " syndrome"}, 32'(out_syndrome), 32'(exp_syn));
    if (release_out) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, " ready_back"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    in_mode   = 2'd0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_word", out_word, 32'd0);
    check("rst status", 32'(out_status), 32'd0);
    check("rst syndrome", 32'(out_syndrome), 32'd0);
    check("rst single", 32'(single_cnt), 32'd0);
    check("rst double", 32'(double_cnt), 32'd0);
    #2 rst = 1'b0;
    tick();
    check("post-rst in_ready", 32'(in_ready), 32'd1);

    // out_ready in IDLE is ignored
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle out_ready", 32'(out_valid), 32'd0);

    // Directed vectors: tag, word, mode, expected word, status, syndrome
    run_word("A 8b 00", 32'h0000_0000, 2'd0, 32'h0000_0000, 2'd0, 5'h00, 1'b1);
    check("A single", 32'(single_cnt), 32'd0);
    check("A double", 32'(double_cnt), 32'd0);
    run_word("B 8b 01", 32'h0000_0001, 2'd0, 32'h0000_0000, 2'd1, 5'h09, 1'b1);
    check("B single", 32'(single_cnt), 32'd1);
    run_word("C 8b 03", 32'h0000_0003, 2'd0, 32'h0000_0003, 2'd2, 5'h03, 1'b1);
    check("C double", 32'(double_cnt), 32'd1);
    run_word("D 16b 8000", 32'h0000_8000, 2'd1, 32'h0000_0000, 2'd1, 5'h1F, 1'b1);
    check("D single", 32'(single_cnt), 32'd2);
    // Valid 8-bit codeword 0x87 with bit 4 flipped; upper garbage masked off
    run_word("E 8b 97", 32'hABCD_0097, 2'd0, 32'h0000_0087, 2'd1, 5'h0B, 1'b1);
    check("E single", 32'(single_cnt), 32'd3);
    run_word("F 16b 0201", 32'h1234_0201, 2'd2, 32'h0000_0201, 2'd2, 5'h08, 1'b1);
    check("F double", 32'(double_cnt), 32'd2);
    run_word("G 16b 0200", 32'h0000_0200, 2'd3, 32'h0000_0000, 2'd1, 5'h19, 1'b1);
    check("G single", 32'(single_cnt), 32'd4);

    // Backpressure: hold the result for 10 cycles
    run_word("H bp", 32'h0000_0001, 2'd0, 32'h0000_0000, 2'd1, 5'h09, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("H hold valid", 32'(out_valid), 32'd1);
      check("H hold word", out_word, 32'h0000_0000);
      check("H hold status", 32'(out_status), 32'd1);
      check("H hold syndrome", 32'(out_syndrome), 32'h09);
      check("H hold in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("H release in_ready", 32'(in_ready), 32'd1);
    check("H single", 32'(single_cnt), 32'd5);
    check("H sat single", 32'(sat_single_cnt), 32'd5);

    // Saturation on the 3-bit instance (max 7)
    for (int k = 6; k <= 8; k++) begin
      run_word("S sat", 32'h0000_0001, 2'd0, 32'h0000_0000, 2'd1, 5'h09, 1'b1);
      check("S single", 32'(single_cnt), 32'(k));
      check("S sat single", 32'(sat_single_cnt), (k > 7) ? 32'd7 : 32'(k));
    end
    check("S sat double", 32'(sat_double_cnt), 32'd2);

    // Leave a nonzero result on the outputs, then reset in CORR
    run_word("C2 8b 03", 32'h0000_0003, 2'd0, 32'h0000_0003, 2'd2, 5'h03, 1'b1);
    check("C2 double", 32'(double_cnt), 32'd3);
    in_valid = 1'b1;
    in_word  = 32'h0000_0001;
    in_mode  = 2'd0;
    tick();                          // SYND
    in_valid = 1'b0;
    tick();                          // CORR
    rst = 1'b1;
    #1;
    check("R in_ready", 32'(in_ready), 32'd0);
    check("R out_valid", 32'(out_valid), 32'd0);
    check("R out_word", out_word, 32'd0);
    check("R status", 32'(out_status), 32'd0);
    check("R syndrome", 32'(out_syndrome), 32'd0);
    check("R single", 32'(single_cnt), 32'd0);
    check("R double", 32'(double_cnt), 32'd0);
    tick();
    #2 rst = 1'b0;
    tick();
    check("R back in_ready", 32'(in_ready), 32'd1);
    check("R back out_valid", 32'(out_valid), 32'd0);

    // Clear together with an increment
    run_word("K1 single", 32'h0000_0001, 2'd0, 32'h0000_0000, 2'd1, 5'h09, 1'b1);
    run_word("K2 double", 32'h0000_0003, 2'd0, 32'h0000_0003, 2'd2, 5'h03, 1'b1);
    check("K pre single", 32'(single_cnt), 32'd1);
    check("K pre double", 32'(double_cnt), 32'd1);
    in_valid = 1'b1;
    in_word  = 32'h0000_0001;
    in_mode  = 2'd0;
    tick();                          // SYND
    in_valid = 1'b0;
    tick();                          // CORR
    clr_cnt = 1'b1;
    tick();                          // OUT, increment overridden by clear
    clr_cnt = 1'b0;
    check("K clr out_valid", 32'(out_valid), 32'd1);
    check("K clr status", 32'(out_status), 32'd1);
    check("K clr single", 32'(single_cnt), 32'd0);
    check("K clr double", 32'(double_cnt), 32'd0);
    check("K clr sat single", 32'(sat_single_cnt), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("K end in_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
